// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU opcode encoding shared by the arbiter and the ALU.
//  ALU_SEL_W       opcode width
//  alu_sel_e       ALU_* opcodes
//  alu_sel_legal() true for any defined ALU_* code
//  alu_sel_shift() true for SLL/SRL/SRA (op2 is masked to a shift amount)
package alu_arbiter_pkg;

  localparam int ALU_SEL_W = 5;
  localparam int NUM_REQ   = 2;

  // Codes are contiguous from ALU_NONE to ALU_LUI, so legality is a single compare.
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_NONE = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_LUI  = 5'd10
  } alu_sel_e;

  function automatic logic alu_sel_legal(input logic [ALU_SEL_W-1:0] sel);
    return sel <= ALU_LUI;
  endfunction

  function automatic logic alu_sel_shift(input logic [ALU_SEL_W-1:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request + response channel.
//  req_valid/req_ready  request handshake, req_op1/req_op2/req_sel operation
//  rsp_valid/rsp_ready  response handshake, rsp_data result, rsp_err illegal opcode
//  master: requester/consumer side; slave: arbiter side.
interface alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_op1;
  logic [XLEN-1:0]  req_op2;
  logic [SEL_W-1:0] req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_op1, req_op2, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU.
//  op1, op2  operands
//  sel       ALU_* opcode (ALU_NONE and undefined codes give 0)
//  res       result; shifts use the low log2(XLEN) bits of op2, LUI is op1 << 12
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      op1,
  input  logic [XLEN-1:0]      op2,
  input  logic [ALU_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      res
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  assign sh = op2[SHW-1:0];

  always_comb begin
    res = '0;
    case (sel)
      ALU_ADD:  res = op1 + op2;
      ALU_SLL:  res = op1 << sh;
      ALU_SLT:  res = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU: res = XLEN'(op1 < op2);
      ALU_XOR:  res = op1 ^ op2;
      ALU_SRL:  res = op1 >> sh;
      ALU_SRA:  res = $signed(op1) >>> sh;
      ALU_OR:   res = op1 | op2;
      ALU_AND:  res = op1 & op2;
      ALU_LUI:  res = op1 << 12;
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin grant.
//  clk, rst_n  clock, async active-low reset
//  req0_if     execute-stage channel (slave)
//  req1_if     address/aux channel (slave)
// A requester is eligible when it is valid and its response slot is empty or
// draining this cycle; the winner drives the ALU and its slot captures at the
// next edge. Illegal opcodes are accepted, produce 0 and flag rsp_err.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave req0_if,
  alu_arbiter_if.slave req1_if
);
  logic [NUM_REQ-1:0]            req_valid, rsp_ready, elig, grant, legal;
  logic [NUM_REQ-1:0]            rsp_valid, rsp_err;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_op1, req_op2, rsp_data;
  logic [NUM_REQ-1:0][SEL_W-1:0] req_sel;
  logic                          last_grant;
  logic                          win;
  logic [XLEN-1:0]               alu_op1, alu_op2, alu_res;
  logic [ALU_SEL_W-1:0]          alu_sel;

  // Flatten the two channels into per-requester arrays.
  assign req_valid = {req1_if.req_valid, req0_if.req_valid};
  assign rsp_ready = {req1_if.rsp_ready, req0_if.rsp_ready};
  assign req_op1   = {req1_if.req_op1,   req0_if.req_op1};
  assign req_op2   = {req1_if.req_op2,   req0_if.req_op2};
  assign req_sel   = {req1_if.req_sel,   req0_if.req_sel};

  assign req0_if.req_ready = grant[0];
  assign req0_if.rsp_valid = rsp_valid[0];
  assign req0_if.rsp_data  = rsp_data[0];
  assign req0_if.rsp_err   = rsp_err[0];
  assign req1_if.req_ready = grant[1];
  assign req1_if.rsp_valid = rsp_valid[1];
  assign req1_if.rsp_data  = rsp_data[1];
  assign req1_if.rsp_err   = rsp_err[1];

  // Contested cycle goes to the requester that did not win last.
  assign grant[0] = elig[0] && (!elig[1] ||  last_grant);
  assign grant[1] = elig[1] && (!elig[0] || !last_grant);
  assign win      = grant[1];

  // Idle and illegal cycles drive ALU_NONE with zero operands.
  always_comb begin
    alu_sel = ALU_NONE;
    alu_op1 = '0;
    alu_op2 = '0;
    if ((|grant) && legal[win]) begin
      alu_sel = req_sel[win];
      alu_op1 = req_op1[win];
      alu_op2 = alu_sel_shift(req_sel[win]) ? {{(XLEN-5){1'b0}}, req_op2[win][4:0]}
                                            : req_op2[win];
    end
  end

  alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
    .op1 (alu_op1),
    .op2 (alu_op2),
    .sel (alu_sel),
    .res (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= 1'b1;
    else if (|grant)  last_grant <= win;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign elig[i]  = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]);
    assign legal[i] = alu_sel_legal(req_sel[i]);

    // Capture wins over drain, so a draining slot can refill in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid[i] <= 1'b0;
        rsp_data[i]  <= '0;
        rsp_err[i]   <= 1'b0;
      end else if (grant[i]) begin
        rsp_valid[i] <= 1'b1;
        rsp_data[i]  <= alu_res;
        rsp_err[i]   <= !legal[i];
      end else if (rsp_ready[i]) begin
        rsp_valid[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(32), .SEL_W(5)) r0 ();
  alu_arbiter_if #(.XLEN(32), .SEL_W(5)) r1 ();

  alu_arbiter #(.XLEN(32), .SEL_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0_if (r0.slave),
    .req1_if (r1.slave)
  );

  // Requesters must hold op/sel while valid && !ready.
  logic        h0 = 1'b0, h1 = 1'b0;
  logic [68:0] s0 = '0, s1 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      h0 <= 1'b0;
      h1 <= 1'b0;
    end else begin
      if (h0 && ({r0.req_op1, r0.req_op2, r0.req_sel} !== s0)) begin
        bad <= bad + 1;
        $display("FAIL hold0 got=%h exp=%h", {r0.req_op1, r0.req_op2, r0.req_sel}, s0);
      end
      if (h1 && ({r1.req_op1, r1.req_op2, r1.req_sel} !== s1)) begin
        bad <= bad + 1;
        $display("FAIL hold1 got=%h exp=%h", {r1.req_op1, r1.req_op2, r1.req_sel}, s1);
      end
      h0 <= r0.req_valid && !r0.req_ready;
      h1 <= r1.req_valid && !r1.req_ready;
      s0 <= {r0.req_op1, r0.req_op2, r0.req_sel};
      s1 <= {r1.req_op1, r1.req_op2, r1.req_sel};
    end
  end

  task automatic drv(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] s);
    if (n == 0) begin
      r0.req_valid = v; r0.req_op1 = a; r0.req_op2 = b; r0.req_sel = s;
    end else begin
      r1.req_valid = v; r1.req_op1 = a; r1.req_op2 = b; r1.req_sel = s;
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_NONE);
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    total++; if (r0.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_v0 got=%b exp=0", r0.rsp_valid); end
    total++; if (r1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_v1 got=%b exp=0", r1.rsp_valid); end
    total++; if (r0.rsp_data !== 32'd0) begin bad++; $display("FAIL rst_d0 got=%h exp=0", r0.rsp_data); end
    total++; if (r1.rsp_data !== 32'd0) begin bad++; $display("FAIL rst_d1 got=%h exp=0", r1.rsp_data); end
    total++; if ({r0.rsp_err, r1.rsp_err} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {r0.rsp_err, r1.rsp_err}); end
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b00) begin bad++; $display("FAIL rst_rdy got=%b exp=00", {r0.req_ready, r1.req_ready}); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    edge1();
  endtask

  task automatic test_single();
    drv(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b10) begin bad++; $display("FAIL t1_rdy got=%b exp=10", {r0.req_ready, r1.req_ready}); end
    edge1();
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if (r0.rsp_valid !== 1'b1) begin bad++; $display("FAIL t1_v0 got=%b exp=1", r0.rsp_valid); end
    total++; if (r0.rsp_data !== 32'd12) begin bad++; $display("FAIL t1_d0 got=%h exp=%h", r0.rsp_data, 32'd12); end
    total++; if (r0.rsp_err !== 1'b0) begin bad++; $display("FAIL t1_e0 got=%b exp=0", r0.rsp_err); end
    edge1();
    total++; if (r0.rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_drain got=%b exp=0", r0.rsp_valid); end
    total++; if (r0.rsp_data !== 32'd12) begin bad++; $display("FAIL t1_hold got=%h exp=%h", r0.rsp_data, 32'd12); end
  endtask

  // last_grant=0 on entry, so req1 takes the first contested cycle.
  task automatic test_contention();
    drv(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    drv(1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b01) begin bad++; $display("FAIL t2_g1 got=%b exp=01", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if ({r1.rsp_valid, r1.rsp_data} !== {1'b1, 32'd1}) begin bad++; $display("FAIL t2_slt got=%h exp=%h", {r1.rsp_valid, r1.rsp_data}, {1'b1, 32'd1}); end
    drv(1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLTU);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b10) begin bad++; $display("FAIL t2_g2 got=%b exp=10", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if ({r0.rsp_valid, r0.rsp_data} !== {1'b1, 32'd3}) begin bad++; $display("FAIL t2_add got=%h exp=%h", {r0.rsp_valid, r0.rsp_data}, {1'b1, 32'd3}); end
    total++; if (r1.rsp_valid !== 1'b0) begin bad++; $display("FAIL t2_drain1 got=%b exp=0", r1.rsp_valid); end
    drv(0, 1'b1, 32'd10, 32'd20, ALU_ADD);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b01) begin bad++; $display("FAIL t2_g3 got=%b exp=01", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if ({r1.rsp_valid, r1.rsp_data} !== {1'b1, 32'd0}) begin bad++; $display("FAIL t2_sltu got=%h exp=%h", {r1.rsp_valid, r1.rsp_data}, {1'b1, 32'd0}); end
    drv(1, 1'b1, 32'h0F, 32'h03, ALU_XOR);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b10) begin bad++; $display("FAIL t2_g4 got=%b exp=10", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if (r0.rsp_data !== 32'd30) begin bad++; $display("FAIL t2_add2 got=%h exp=%h", r0.rsp_data, 32'd30); end
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    edge1();
    drv(1, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if (r1.rsp_data !== 32'h0C) begin bad++; $display("FAIL t2_xor got=%h exp=%h", r1.rsp_data, 32'h0C); end
  endtask

  // last_grant=1 on entry.
  task automatic test_backpressure();
    r0.rsp_ready = 1'b0;
    drv(0, 1'b1, 32'hFF, 32'h0F, ALU_AND);
    drv(1, 1'b1, 32'd100, 32'd1, ALU_ADD);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b10) begin bad++; $display("FAIL t3_g0 got=%b exp=10", {r0.req_ready, r1.req_ready}); end
    edge1();
    drv(0, 1'b1, 32'hAA, 32'h55, ALU_XOR);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b01) begin bad++; $display("FAIL t3_full0 got=%b exp=01", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if (r1.rsp_data !== 32'd101) begin bad++; $display("FAIL t3_d1a got=%h exp=%h", r1.rsp_data, 32'd101); end
    total++; if ({r0.rsp_valid, r0.rsp_data} !== {1'b1, 32'h0F}) begin bad++; $display("FAIL t3_stall got=%h exp=%h", {r0.rsp_valid, r0.rsp_data}, {1'b1, 32'h0F}); end
    drv(1, 1'b1, 32'd200, 32'd2, ALU_ADD);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b01) begin bad++; $display("FAIL t3_again got=%b exp=01", {r0.req_ready, r1.req_ready}); end
    edge1();
    total++; if (r1.rsp_data !== 32'd202) begin bad++; $display("FAIL t3_d1b got=%h exp=%h", r1.rsp_data, 32'd202); end
    drv(1, 1'b0, 32'd0, 32'd0, ALU_NONE);
    r0.rsp_ready = 1'b1;
    #1;
    total++; if (r0.req_ready !== 1'b1) begin bad++; $display("FAIL t3_refill_rdy got=%b exp=1", r0.req_ready); end
    edge1();
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if ({r0.rsp_valid, r0.rsp_data} !== {1'b1, 32'hFF}) begin bad++; $display("FAIL t3_refill got=%h exp=%h", {r0.rsp_valid, r0.rsp_data}, {1'b1, 32'hFF}); end
    edge1();
    total++; if (r0.rsp_valid !== 1'b0) begin bad++; $display("FAIL t3_drain got=%b exp=0", r0.rsp_valid); end
  endtask

  task automatic test_illegal();
    drv(1, 1'b1, 32'd3, 32'd4, 5'h1F);
    #1;
    total++; if (r1.req_ready !== 1'b1) begin bad++; $display("FAIL t4_rdy got=%b exp=1", r1.req_ready); end
    edge1();
    total++; if ({r1.rsp_valid, r1.rsp_err, r1.rsp_data} !== {2'b11, 32'd0}) begin bad++; $display("FAIL t4_ill got=%h exp=%h", {r1.rsp_valid, r1.rsp_err, r1.rsp_data}, {2'b11, 32'd0}); end
    drv(1, 1'b1, 32'hF0, 32'h0F, ALU_OR);
    edge1();
    drv(1, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if ({r1.rsp_err, r1.rsp_data} !== {1'b0, 32'hFF}) begin bad++; $display("FAIL t4_or got=%h exp=%h", {r1.rsp_err, r1.rsp_data}, {1'b0, 32'hFF}); end
    total++; if (r0.rsp_err !== 1'b0) begin bad++; $display("FAIL t4_e0 got=%b exp=0", r0.rsp_err); end
  endtask

  task automatic test_shift();
    drv(0, 1'b1, 32'h8000_0000, 32'h21, ALU_SRA);
    edge1();
    total++; if (r0.rsp_data !== 32'hC000_0000) begin bad++; $display("FAIL t5_sra got=%h exp=%h", r0.rsp_data, 32'hC000_0000); end
    drv(0, 1'b1, 32'd1, 32'h24, ALU_SLL);
    edge1();
    total++; if (r0.rsp_data !== 32'h10) begin bad++; $display("FAIL t5_sll got=%h exp=%h", r0.rsp_data, 32'h10); end
    drv(0, 1'b1, 32'h12345, 32'd0, ALU_LUI);
    edge1();
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if (r0.rsp_data !== 32'h1234_5000) begin bad++; $display("FAIL t5_lui got=%h exp=%h", r0.rsp_data, 32'h1234_5000); end
    edge1();
  endtask

  // last_grant=0 on entry; after reset req0 must win even though it won last.
  task automatic test_async_reset();
    r0.rsp_ready = 1'b0;
    r1.rsp_ready = 1'b0;
    drv(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    drv(1, 1'b1, 32'd2, 32'd2, ALU_ADD);
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b01) begin bad++; $display("FAIL t6_g1 got=%b exp=01", {r0.req_ready, r1.req_ready}); end
    edge1();
    edge1();
    total++; if ({r0.rsp_valid, r1.rsp_valid, r0.req_ready, r1.req_ready} !== 4'b1100) begin bad++; $display("FAIL t6_full got=%b exp=1100", {r0.rsp_valid, r1.rsp_valid, r0.req_ready, r1.req_ready}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({r0.rsp_valid, r1.rsp_valid} !== 2'b00) begin bad++; $display("FAIL t6_rstv got=%b exp=00", {r0.rsp_valid, r1.rsp_valid}); end
    total++; if (r0.rsp_data !== 32'd0) begin bad++; $display("FAIL t6_rstd got=%h exp=0", r0.rsp_data); end
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    #3 rst_n = 1'b1;
    #1;
    total++; if ({r0.req_ready, r1.req_ready} !== 2'b10) begin bad++; $display("FAIL t6_first got=%b exp=10", {r0.req_ready, r1.req_ready}); end
    edge1();
    drv(0, 1'b0, 32'd0, 32'd0, ALU_NONE);
    drv(1, 1'b0, 32'd0, 32'd0, ALU_NONE);
    total++; if ({r0.rsp_valid, r0.rsp_data, r1.rsp_valid} !== {1'b1, 32'd2, 1'b0}) begin bad++; $display("FAIL t6_post got=%h exp=%h", {r0.rsp_valid, r0.rsp_data, r1.rsp_valid}, {1'b1, 32'd2, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_shift();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
